mem_responder: RTL and testbench

Memory-side responder for the processor's data/instruction memory port: accepts one read or write request at a time over a valid/ready handshake, inserts a fixed number of wait states, and returns exactly one response per request. Supports byte, halfword and word accesses with lane merge on writes and zero-extension on reads, and flags misaligned or out-of-range accesses. It sits between the CPU's address/write-data mux outputs and the MDR/IR load path, replacing the fixed-latency memory macro when variable latency is needed.

---
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/mem_lane_merge.sv | 39 +++
 rtl/mem_responder.sv | 148 ++++++++++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared encodings, FSM state type and access-error check for mem_responder.
package mem_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  // limit is the first out-of-range byte address (4 * depth in words).
  function automatic logic access_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [33:0] limit);
    logic err;
    err = (size == SZ_ILL)
        | ((size == SZ_HALF) & addr[0])
        | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
        | ({2'b00, addr} >= limit);
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational lane extract (zero-extended read) and lane merge (write).
module mem_lane_merge
  import mem_responder_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  logic [4:0] byte_sh;
  logic [4:0] half_sh;

  assign byte_sh = {lane_i, 3'b000};
  assign half_sh = {lane_i[1], 4'b0000};

  always_comb begin
    rdata_o  = '0;
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: begin
        rdata_o[7:0]            = old_word_i[byte_sh +: 8];
        merged_o[byte_sh +: 8]  = wdata_i[7:0];
      end
      SZ_HALF: begin
        rdata_o[15:0]           = old_word_i[half_sh +: 16];
        merged_o[half_sh +: 16] = wdata_i[15:0];
      end
      SZ_WORD: begin
        rdata_o  = old_word_i;
        merged_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: fixed wait states, byte/half/word lanes,
// error flagging for misaligned, illegal-size and out-of-range accesses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [33:0] ByteLim  = 34'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CntLoad  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        enter_resp;
  logic        cur_write;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic [31:0] old_word;
  logic [31:0] lane_rdata;
  logic [31:0] merged;
  logic        mem_we;

  // With zero wait states the storage access happens on the acceptance edge,
  // so the live request is used instead of the (not yet loaded) latch.
  assign cur_write = (state_q == StIdle) ? req_write_i : wr_q;
  assign cur_size  = (state_q == StIdle) ? req_size_i  : size_q;
  assign cur_addr  = (state_q == StIdle) ? req_addr_i  : addr_q;
  assign cur_wdata = (state_q == StIdle) ? req_wdata_i : wdata_q;
  assign cur_err   = access_err(cur_size, cur_addr, ByteLim);
  assign old_word  = mem_q[cur_addr[IdxW+1:2]];

  mem_lane_merge u_lane_merge (
    .size_i     (cur_size),
    .lane_i     (cur_addr[1:0]),
    .old_word_i (old_word),
    .wdata_i    (cur_wdata),
    .rdata_o    (lane_rdata),
    .merged_o   (merged)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          wr_d    = req_write_i;
          size_d  = req_size_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (WAIT_CYCLES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (enter_resp) begin
      err_d   = cur_err;
      rdata_d = (cur_err || cur_write) ? 32'd0 : lane_rdata;
    end
  end

  // Reset held across an edge must not commit a write still pending.
  assign mem_we = enter_resp & cur_write & ~cur_err & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[cur_addr[IdxW+1:2]] <= merged;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign resp_valid_o = (state_q == StResp);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (1 and 0 wait states) against an arithmetic memory model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        v1, v0;
  logic        r1, r0, rv1, rv0, e1, e0;
  logic [31:0] rd1, rd0;

  int tests = 0;
  int fails = 0;
  logic [31:0] mdl [2][256];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_ready_o(r1),
    .req_write_i(req_write), .req_size_i(req_size), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(rv1), .resp_rdata_o(rd1), .resp_err_o(e1)
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v0), .req_ready_o(r0),
    .req_write_i(req_write), .req_size_i(req_size), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(rv0), .resp_rdata_o(rd0), .resp_err_o(e0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int w);  return w != 0 ? r1  : r0;  endfunction
  function automatic logic rsp(input int w);  return w != 0 ? rv1 : rv0; endfunction
  function automatic logic [31:0] rdat(input int w); return w != 0 ? rd1 : rd0; endfunction
  function automatic logic rerr(input int w); return w != 0 ? e1  : e0;  endfunction

  function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
        || (a >= 32'd1024);
  endfunction

  function automatic logic [31:0] m_mask(input logic [1:0] sz);
    return (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] m_read(input int w, input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] word;
    word = mdl[w][a / 4];
    return (word >> ((a % 4) * 8)) & m_mask(sz);
  endfunction

  task automatic m_write(input int w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d);
    logic [31:0] mask;
    mask = m_mask(sz) << ((a % 4) * 8);
    mdl[w][a / 4] = (mdl[w][a / 4] & ~mask) | ((d << ((a % 4) * 8)) & mask);
  endtask

  task automatic drive(input int w, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    req_write = wr; req_size = sz; req_addr = a; req_wdata = d;
    if (w != 0) v1 = 1'b1; else v0 = 1'b1;
  endtask

  task automatic scramble();
    v1 = 1'b0; v0 = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic txn(input int w, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d, input string tag);
    int lat;
    logic exp_e;
    logic [31:0] exp_d;
    exp_e = m_err(sz, a);
    exp_d = (exp_e || wr) ? 32'd0 : m_read(w, sz, a);
    chk({tag, ":ready_idle"}, 32'(rdy(w)), 32'd1);
    drive(w, wr, sz, a, d);
    @(posedge clk); #1;
    scramble();
    chk({tag, ":ready_busy"}, 32'(rdy(w)), 32'd0);
    lat = 1;
    while (!rsp(w) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ":latency"}, 32'(lat), (w != 0) ? 32'd2 : 32'd1);
    last_rd = rdat(w);
    chk({tag, ":rdata"}, rdat(w), exp_d);
    chk({tag, ":err"}, 32'(rerr(w)), 32'(exp_e));
    if (!exp_e && wr) m_write(w, sz, a, d);
    @(posedge clk); #1;
    chk({tag, ":post_valid"}, 32'(rsp(w)), 32'd0);
    chk({tag, ":post_rdata"}, rdat(w), 32'd0);
    chk({tag, ":post_err"}, 32'(rerr(w)), 32'd0);
  endtask

  initial begin
    rst = 1'b1; v1 = 1'b0; v0 = 1'b0;
    req_write = 1'b0; req_size = 2'd0; req_addr = '0; req_wdata = '0;
    #1;
    for (int w = 0; w < 2; w++) begin
      chk("reset:ready", 32'(rdy(w)), 32'd1);
      chk("reset:valid", 32'(rsp(w)), 32'd0);
      chk("reset:rdata", rdat(w), 32'd0);
      chk("reset:err", 32'(rerr(w)), 32'd0);
    end
    #11 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) begin
      txn(1, 1'b1, 2'd2, 32'(i * 4), $urandom, "preload1");
      txn(0, 1'b1, 2'd2, 32'(i * 4), $urandom, "preload0");
    end

    // Directed lane sequence on the one-wait-state responder.
    txn(1, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, "w_word");
    txn(1, 1'b0, 2'd2, 32'h10, 32'h0, "r_word");
    chk("r_word:const", last_rd, 32'hDEADBEEF);
    txn(1, 1'b1, 2'd0, 32'h11, 32'h000000AA, "w_byte");
    txn(1, 1'b0, 2'd2, 32'h10, 32'h0, "r_word2");
    chk("r_word2:const", last_rd, 32'hDEADAAEF);
    txn(1, 1'b0, 2'd0, 32'h13, 32'h0, "r_byte");
    chk("r_byte:const", last_rd, 32'h000000DE);
    txn(1, 1'b1, 2'd1, 32'h12, 32'h00001234, "w_half");
    txn(1, 1'b0, 2'd1, 32'h12, 32'h0, "r_half");
    chk("r_half:const", last_rd, 32'h00001234);
    txn(1, 1'b0, 2'd2, 32'h10, 32'h0, "r_word3");
    chk("r_word3:const", last_rd, 32'h1234AAEF);
    txn(1, 1'b0, 2'd1, 32'h11, 32'h0, "e_half_mis");
    txn(1, 1'b1, 2'd2, 32'h12, 32'hFFFFFFFF, "e_word_mis");
    txn(1, 1'b1, 2'd3, 32'h10, 32'hFFFFFFFF, "e_size");
    txn(1, 1'b1, 2'd2, 32'h400, 32'hFFFFFFFF, "e_range");
    txn(1, 1'b0, 2'd2, 32'h10, 32'h0, "r_word4");
    chk("r_word4:const", last_rd, 32'h1234AAEF);

    // Reset during WAIT aborts the write without a response.
    drive(1, 1'b1, 2'd2, 32'h20, 32'h5555AAAA);
    @(posedge clk); #1;
    scramble();
    chk("rst_wait:busy", 32'(r1), 32'd0);
    rst = 1'b1; #2; rst = 1'b0;
    chk("rst_wait:ready", 32'(r1), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_wait:no_resp", 32'(rv1), 32'd0);
    end
    txn(1, 1'b0, 2'd2, 32'h20, 32'h0, "rst_wait:read");

    // Reset during RESP: write already committed, strobe drops at once.
    drive(1, 1'b1, 2'd2, 32'h24, 32'hCAFEF00D);
    @(posedge clk); #1;
    scramble();
    @(posedge clk); #1;
    chk("rst_resp:valid", 32'(rv1), 32'd1);
    rst = 1'b1; #1;
    chk("rst_resp:drop", 32'(rv1), 32'd0);
    rst = 1'b0;
    m_write(1, 2'd2, 32'h24, 32'hCAFEF00D);
    @(posedge clk); #1;
    txn(1, 1'b0, 2'd2, 32'h24, 32'h0, "rst_resp:read");

    // Zero-wait responder with valid held: accept every other cycle.
    drive(0, 1'b0, 2'd2, 32'h40, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("b2b:ready", 32'(r0), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("b2b:valid", 32'(rv0), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("b2b:rdata", rd0, m_read(0, 2'd2, 32'h40));
    end
    scramble();
    @(posedge clk); #1;

    for (int n = 0; n < 300; n++) begin
      int w;
      logic [31:0] a;
      w = n % 2;
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      txn(w, 1'($urandom), 2'($urandom_range(0, 3)), a, $urandom, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
